register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
- Parametrised successor to the single-write, two-read register file used in the RISC-V datapath.
- Adds a configurable number of read ports and optional write-to-read bypass.
- Adds a per-register busy scoreboard for pipeline hazard detection: set when a destination is issued, cleared at writeback.
- Sits between the decode/issue stage (read, reserve) and the writeback stage (write, release).

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of registers; must be a power of two and at least 2.
- NUM_RD, 2, number of read ports, 1..4.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports and to the busy view.
- Derived constant AW = $clog2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback register index.
- wr_data  in  WIDTH  writeback data.
- rd_addr  in  NUM_RD*AW  packed read indices; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*WIDTH  packed read data; port i occupies bits [i*WIDTH +: WIDTH].
- rd_busy  out  NUM_RD  busy flag of the register addressed by each read port.
- iss_en  in  1  reserve a destination register (sets its busy bit).
- iss_addr  in  AW  index of the destination being reserved.
- busy_vec  out  DEPTH  registered scoreboard, bit r = register r busy.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high, sampled on the rising edge.
- Reset effects: all registers clear to 0 and all busy bits clear to 0 on the next edge. rst dominates wr_en and iss_en in the same cycle.
- Register 0: always reads 0 and is never busy.
  - Writes to address 0 are ignored.
  - Issues to address 0 are ignored.
  - busy_vec[0] is constant 0.
- Write: if wr_en and wr_addr != 0, regs[wr_addr] <= wr_data at the edge. Without bypass the value is visible on reads in the next cycle.
- Read: combinational from rd_addr, zero latency. All ports are independent; any number may address the same register.
- Bypass (BYPASS=1): if wr_en and wr_addr == rd_addr[i] and rd_addr[i] != 0, then rd_data[i] = wr_data in the same cycle.
- Busy bits: busy[r] is the registered scoreboard bit.
  - Set when iss_en and iss_addr == r, r != 0.
  - Cleared when wr_en and wr_addr == r.
  - Both in the same cycle on the same r: set wins (new producer reserves the register after the old one retires).
  - Issue to an already busy register: it stays busy. One bit per register; in-order writeback is the issue stage's guarantee.
  - A write to a non-busy register is legal and leaves the bit at 0.
- rd_busy[i] with BYPASS=1: busy[rd_addr[i]] AND NOT (wr_en AND wr_addr == rd_addr[i]).
- rd_busy[i] with BYPASS=0: busy[rd_addr[i]] only.
- Same-cycle issue does not affect rd_busy; the new busy bit is visible from the next cycle.
- Outputs after reset: rd_data all 0, rd_busy all 0, busy_vec all 0.
- Reset mid-operation: all pending reservations are discarded. A write presented with rst high is lost.

Decomposition:
- Package rf_pkg holds:
  - default constants RF_WIDTH=32, RF_DEPTH=32, RF_NUM_RD=2;
  - function rf_aw(depth) returning $clog2(depth);
  - typedef rf_addr_t sized for the default depth.
- Sub-module rf_read_port, instantiated NUM_RD times in a generate loop. It contains:
  - the read mux;
  - the bypass compare;
  - the zero-register override;
  - the rd_busy masking.
- The storage array and scoreboard stay in the top module.

Test Plan:
- rst held 3 cycles after random writes → every register reads 0 on all ports; busy_vec = 0.
- Write 0xDEADBEEF to r5 with BYPASS=1 and rd_addr port0 = 5 in the same cycle → rd_data port0 = 0xDEADBEEF that cycle. With BYPASS=0 → the old value that cycle, 0xDEADBEEF the next.
- iss_en to r7, then 3 idle cycles, then wr_en to r7 = 0x12345678 → busy_vec[7] is 1 for 4 cycles, 0 after the write edge. rd_busy for r7 drops in the write cycle (BYPASS=1).
- Simultaneous iss_en and wr_en to r9 → busy_vec[9] = 1 afterwards and r9 holds the written data.
- Write 0xFFFFFFFF and issue to r0 → r0 reads 0 and busy_vec[0] = 0 on all ports.
- Random stream of 500 cycles with NUM_RD=4, DEPTH=16 → all ports match a golden array plus scoreboard model every cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package rf_pkg;

  localparam int unsigned RF_WIDTH  = 32;
  localparam int unsigned RF_DEPTH  = 32;
  localparam int unsigned RF_NUM_RD = 2;

  // Address width needed to index a register file of the given depth.
  function automatic int unsigned rf_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned RF_AW = rf_aw(RF_DEPTH);

  typedef logic [RF_AW-1:0] rf_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array mux, write forwarding, r0 override, busy masking.
module rf_read_port #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic [AW-1:0]                i_rd_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  i_regs,
  input  logic [DEPTH-1:0]             i_busy,
  input  logic                         i_wr_en,
  input  logic [AW-1:0]                i_wr_addr,
  input  logic [WIDTH-1:0]             i_wr_data,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic                         o_rd_busy
);

  logic w_hit;

  // Select stored value, override with in-flight write, then force r0 to idle zero.
  always_comb begin
    w_hit     = (BYPASS != 0) && i_wr_en && (i_wr_addr == i_rd_addr);
    o_rd_data = i_regs[i_rd_addr];
    o_rd_busy = i_busy[i_rd_addr];
    if (w_hit) begin
      // The retiring write satisfies the hazard this cycle.
      o_rd_data = i_wr_data;
      o_rd_busy = 1'b0;
    end
    if (i_rd_addr == '0) begin
      o_rd_data = '0;
      o_rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with optional write bypass and a busy scoreboard.
// Register 0 is hardwired to zero and can never be reserved.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned NUM_RD = RF_NUM_RD,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = rf_aw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  output logic [DEPTH-1:0]        busy_vec
);

  logic [DEPTH-1:0][WIDTH-1:0] r_regs;
  logic [DEPTH-1:0]            r_busy;
  logic [DEPTH-1:0]            w_busy_d;

  // Storage update: writeback to any register except r0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard next state: writeback releases, issue reserves; issue applied last so it wins.
  always_comb begin
    w_busy_d = r_busy;
    for (int unsigned r = 1; r < DEPTH; r++) begin
      if (wr_en && (wr_addr == AW'(r))) begin
        w_busy_d[r] = 1'b0;
      end
      if (iss_en && (iss_addr == AW'(r))) begin
        w_busy_d[r] = 1'b1;
      end
    end
    w_busy_d[0] = 1'b0;
  end

  // Scoreboard register; reset discards all pending reservations.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign busy_vec = r_busy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rd (
      .i_rd_addr (rd_addr[i*AW +: AW]),
      .i_regs    (r_regs),
      .i_busy    (r_busy),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_rd_data (rd_data[i*WIDTH +: WIDTH]),
      .o_rd_busy (rd_busy[i])
    );
  end

endmodule
